// File: rtl/llr_frame_buffer.sv
// Ping-pong LLR input buffer: saturates raw soft values, fills one bank while the
// decoder randomly reads the other completed bank, frames handed over in FIFO order.
module llr_frame_buffer #(
    parameter int log2n       = 4,
    parameter int n           = 12,
    parameter int n_minus_one = 11,
    parameter int raw_w       = 8,
    parameter int llr_w       = 6
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    input  logic signed [raw_w-1:0] in_raw,
    output logic                    in_ready,
    input  logic        [log2n-1:0] rd_addr,
    output logic signed [llr_w-1:0] rd_llr,
    output logic                    frame_valid,
    input  logic                    frame_done,
    output logic        [log2n-1:0] fill_count,
    output logic        [1:0]       state
);

    localparam logic        [log2n-1:0] last_idx = log2n'(n_minus_one);
    localparam logic signed [llr_w-1:0] llr_max  = {1'b0, {(llr_w-1){1'b1}}};
    localparam logic signed [llr_w-1:0] llr_min  = {1'b1, {(llr_w-1){1'b0}}};

    function automatic logic signed [llr_w-1:0] sat_llr(input logic signed [raw_w-1:0] x);
        logic signed [raw_w-1:0] hi;
        logic signed [raw_w-1:0] lo;
        hi = {{(raw_w-llr_w){1'b0}}, llr_max};
        lo = {{(raw_w-llr_w){1'b1}}, llr_min};
        if (x > hi) begin
            sat_llr = llr_max;
        end else if (x < lo) begin
            sat_llr = llr_min;
        end else begin
            sat_llr = x[llr_w-1:0];
        end
    endfunction

    logic signed [llr_w-1:0] bank [2][n];
    logic                    wb;
    logic                    rb;
    logic        [1:0]       full;
    logic        [1:0]       full_nxt;
    logic        [1:0]       state_nxt;
    logic                    xfer;
    logic                    frame_end;
    logic                    release_rb;

    // in_ready depends only on registers so upstream sees no combinational loop
    assign in_ready    = !full[wb];
    assign frame_valid = full[rb];

    assign xfer       = in_valid && in_ready;
    assign frame_end  = xfer && (fill_count == last_idx);
    assign release_rb = frame_done && full[rb];

    // A completing write always targets the empty bank while a release targets the
    // full read bank, so both updates can be applied together.
    always_comb begin
        full_nxt = full;
        if (frame_end) begin
            full_nxt[wb] = 1'b1;
        end
        if (release_rb) begin
            full_nxt[rb] = 1'b0;
        end
        state_nxt = {1'b0, full_nxt[0]} + {1'b0, full_nxt[1]};
    end

    // Control stage: bank pointers, full flags, fill counter, occupancy
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wb         <= 1'b0;
            rb         <= 1'b0;
            full       <= 2'b00;
            fill_count <= '0;
            state      <= 2'd0;
        end else begin
            full  <= full_nxt;
            state <= state_nxt;
            if (xfer) begin
                fill_count <= frame_end ? '0 : fill_count + 1'b1;
            end
            if (frame_end) begin
                wb <= ~wb;
            end
            if (release_rb) begin
                rb <= ~rb;
            end
        end
    end

    // Write stage: saturated value into the current write bank
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bank <= '{default: '0};
        end else if (xfer) begin
            bank[wb][fill_count] <= sat_llr(in_raw);
        end
    end

    // Read stage: one-cycle registered random access into the read bank
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_llr <= '0;
        end else if (rd_addr > last_idx) begin
            rd_llr <= '0;
        end else begin
            rd_llr <= bank[rb][rd_addr];
        end
    end

endmodule

// File: tb/tb_llr_frame_buffer.sv
// Directed bench for llr_frame_buffer: a frame-FIFO model checked every cycle,
// plus literal expectations taken from hand-worked scenarios.
module tb_llr_frame_buffer;

    localparam int log2n = 4;
    localparam int n     = 12;
    localparam int raw_w = 8;
    localparam int llr_w = 6;

    typedef logic [n*llr_w-1:0] frame_t;

    logic                    clk = 1'b0;
    logic                    rst = 1'b0;
    logic                    in_valid = 1'b0;
    logic signed [raw_w-1:0] in_raw = '0;
    logic                    in_ready;
    logic        [log2n-1:0] rd_addr = '0;
    logic signed [llr_w-1:0] rd_llr;
    logic                    frame_valid;
    logic                    frame_done = 1'b0;
    logic        [log2n-1:0] fill_count;
    logic        [1:0]       state;

    int total = 0;
    int bad   = 0;

    llr_frame_buffer #(
        .log2n(log2n), .n(n), .n_minus_one(n-1), .raw_w(raw_w), .llr_w(llr_w)
    ) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_raw(in_raw),
        .in_ready(in_ready), .rd_addr(rd_addr), .rd_llr(rd_llr),
        .frame_valid(frame_valid), .frame_done(frame_done),
        .fill_count(fill_count), .state(state)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: a partial frame being assembled and a FIFO of completed frames.
    frame_t fq[$];
    frame_t cur = '0;
    int     m_fill = 0;
    int     e_rd = 0;
    bit     e_rd_known = 1'b1;
    bit     acc;
    bit     rel;

    function automatic logic [llr_w-1:0] sat_model(input int v);
        int lim_hi;
        int lim_lo;
        int r;
        lim_hi = (1 << (llr_w-1)) - 1;
        lim_lo = -(1 << (llr_w-1));
        r = (v > lim_hi) ? lim_hi : (v < lim_lo) ? lim_lo : v;
        return r[llr_w-1:0];
    endfunction

    function automatic int elem(input frame_t f, input int a);
        logic signed [llr_w-1:0] t;
        t = f[a*llr_w +: llr_w];
        return int'(t);
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            fq.delete();
            cur        = '0;
            m_fill     = 0;
            e_rd       = 0;
            e_rd_known = 1'b1;
        end else begin
            if (rd_addr > 4'(n-1)) begin
                e_rd = 0;
                e_rd_known = 1'b1;
            end else if (fq.size() > 0) begin
                e_rd = elem(fq[0], int'(rd_addr));
                e_rd_known = 1'b1;
            end else begin
                e_rd_known = 1'b0;
            end
            acc = in_valid && (fq.size() < 2);
            rel = frame_done && (fq.size() > 0);
            if (rel) begin
                void'(fq.pop_front());
            end
            if (acc) begin
                cur[m_fill*llr_w +: llr_w] = sat_model(int'(in_raw));
                m_fill++;
                if (m_fill == n) begin
                    fq.push_back(cur);
                    m_fill = 0;
                end
            end
        end
    end

    always @(negedge clk) begin
        check("fill_count", int'(fill_count), m_fill);
        check("state", int'(state), fq.size());
        check("frame_valid", int'(frame_valid), int'(fq.size() > 0));
        check("in_ready", int'(in_ready), int'(fq.size() < 2));
        if (e_rd_known) begin
            check("rd_llr", int'(rd_llr), e_rd);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_done();
        frame_done = 1'b1;
        tick();
        frame_done = 1'b0;
    endtask

    int sat_in[6]  = '{100, -100, 31, -32, 127, -128};
    int sat_exp[6] = '{31, -32, 31, -32, 31, -32};

    initial begin
        rst = 1'b0;
        repeat (2) tick();
        check("rst_fill", int'(fill_count), 0);
        check("rst_state", int'(state), 0);
        check("rst_fv", int'(frame_valid), 0);
        check("rst_ready", int'(in_ready), 1);
        check("rst_rd", int'(rd_llr), 0);
        rst = 1'b1;
        tick();

        // Stream 0..11 back to back
        in_valid = 1'b1;
        for (int i = 0; i < n; i++) begin
            in_raw = 8'(i);
            tick();
            check("fill_seq", int'(fill_count), (i + 1) % n);
        end
        in_valid = 1'b0;
        check("frame0_fv", int'(frame_valid), 1);
        check("frame0_state", int'(state), 1);
        for (int a = 0; a < n; a++) begin
            rd_addr = 4'(a);
            tick();
            check("rd_frame0", int'(rd_llr), a);
        end
        pulse_done();
        check("done_state", int'(state), 0);

        // Saturation
        in_valid = 1'b1;
        for (int i = 0; i < n; i++) begin
            in_raw = (i < 6) ? 8'(sat_in[i]) : 8'(i);
            tick();
        end
        in_valid = 1'b0;
        for (int a = 0; a < 6; a++) begin
            rd_addr = 4'(a);
            tick();
            check("sat_rd", int'(rd_llr), sat_exp[a]);
        end
        pulse_done();

        // Backpressure: two full banks, 25th value held off
        in_valid = 1'b1;
        for (int i = 0; i < 2*n; i++) begin
            in_raw = 8'(i + 1);
            tick();
        end
        check("bp_state", int'(state), 2);
        check("bp_ready", int'(in_ready), 0);
        in_raw = 8'(25);
        repeat (3) tick();
        check("bp_hold_fill", int'(fill_count), 0);
        check("bp_hold_ready", int'(in_ready), 0);
        frame_done = 1'b1;
        tick();
        frame_done = 1'b0;
        check("bp_release_ready", int'(in_ready), 1);
        tick();
        in_valid = 1'b0;
        check("bp_25_fill", int'(fill_count), 1);
        rd_addr = 4'd0;
        tick();
        check("rd_frame2", int'(rd_llr), 13);
        in_valid = 1'b1;
        for (int i = 0; i < n-1; i++) begin
            in_raw = 8'(26 + i);
            tick();
        end
        in_valid = 1'b0;
        frame_done = 1'b1;
        tick();
        frame_done = 1'b0;
        tick();
        check("bp_25_idx0", int'(rd_llr), 25);
        rd_addr = 4'd11;
        tick();
        check("bp_sat_idx11", int'(rd_llr), 31);
        pulse_done();
        check("bp_empty_state", int'(state), 0);

        // Frame completion and frame_done on the same edge
        in_valid = 1'b1;
        for (int i = 0; i < n; i++) begin
            in_raw = 8'(-1 - i);
            tick();
        end
        for (int i = 0; i < n-1; i++) begin
            in_raw = 8'(2*i - 10);
            tick();
        end
        in_raw = 8'(12);
        frame_done = 1'b1;
        tick();
        in_valid = 1'b0;
        frame_done = 1'b0;
        check("simul_state", int'(state), 1);
        check("simul_fv", int'(frame_valid), 1);
        check("simul_fill", int'(fill_count), 0);
        rd_addr = 4'd3;
        tick();
        check("simul_rd3", int'(rd_llr), -4);
        rd_addr = 4'd11;
        tick();
        check("simul_rd11", int'(rd_llr), 12);
        pulse_done();

        // frame_done with no valid frame is ignored; out-of-range read gives 0
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            in_raw = 8'(i + 7);
            tick();
        end
        in_valid = 1'b0;
        pulse_done();
        check("ign_state", int'(state), 0);
        check("ign_fill", int'(fill_count), 5);
        check("ign_fv", int'(frame_valid), 0);
        rd_addr = 4'd13;
        tick();
        check("rd_oob", int'(rd_llr), 0);

        // Reset in the middle of a partial frame
        in_valid = 1'b1;
        in_raw = 8'(1);
        repeat (2) tick();
        in_valid = 1'b0;
        check("pre_rst_fill", int'(fill_count), 7);
        rst = 1'b0;
        #2;
        check("mid_rst_fill", int'(fill_count), 0);
        check("mid_rst_state", int'(state), 0);
        check("mid_rst_fv", int'(frame_valid), 0);
        check("mid_rst_ready", int'(in_ready), 1);
        check("mid_rst_rd", int'(rd_llr), 0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        in_valid = 1'b1;
        for (int i = 0; i < n; i++) begin
            in_raw = 8'(3*i - 16);
            tick();
        end
        in_valid = 1'b0;
        check("post_rst_fv", int'(frame_valid), 1);
        for (int a = 0; a < n; a++) begin
            rd_addr = 4'(a);
            tick();
            check("post_rst_rd", int'(rd_llr), 3*a - 16);
        end
        pulse_done();
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
